bit_packer: RTL and testbench

Output stage of the compressor, directly downstream of the merge logic that ORs compressed code words into a shared bit array. It takes variable-length compressed chunks of up to 68 bits, appends them MSB-first into a 136-bit holding buffer, and emits fixed 32-bit words over a valid/ready handshake. A flush command drains the partial tail zero-padded and marks the final word.

---
 rtl/bit_packer_if.sv | 27 ++
 rtl/bit_packer.sv | 104 ++++++++++
 tb/tb_bit_packer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_packer_if.sv
// Handshake bundle for the bit packer: chunk push side, word pop side, flush and status.
interface bit_packer_if #(
  parameter int I_WIDTH = 68,
  parameter int O_WIDTH = 32
);
  logic               push_valid;
  logic [I_WIDTH-1:0] push_code;
  logic [6:0]         push_len;
  logic               push_ready;
  logic               flush;
  logic               pop_valid;
  logic [O_WIDTH-1:0] pop_data;
  logic               pop_last;
  logic               pop_ready;
  logic               done;
  logic [15:0]        word_count;

  modport master (
    output push_valid, push_code, push_len, flush, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_last, done, word_count
  );

  modport slave (
    input  push_valid, push_code, push_len, flush, pop_ready,
    output push_ready, pop_valid, pop_data, pop_last, done, word_count
  );
endinterface

// File: rtl/bit_packer.sv
// Appends variable-length chunks MSB-first into a holding buffer and emits fixed-width words;
// a flush drains the zero-padded tail and flags the final word.
//
// state   | meaning
// S_RUN   | accepting chunks, emitting full words
// S_FLUSH | no pushes; draining remaining bits, last word padded
// S_DONE  | one-cycle completion pulse, buffer cleared
module bit_packer #(
  parameter int I_WIDTH   = 68,
  parameter int BUF_WIDTH = 136,
  parameter int O_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  bit_packer_if.slave pk
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [7:0] BUF_CNT  = 8'(BUF_WIDTH);
  localparam logic [7:0] PUSH_MAX = 8'(BUF_WIDTH - I_WIDTH);
  localparam logic [7:0] WORD_CNT = 8'(O_WIDTH);
  localparam logic [6:0] LEN_MAX  = 7'(I_WIDTH);

  state_t               state_q, state_d;
  logic [BUF_WIDTH-1:0] hold_q, hold_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          wcount_q, wcount_d;

  logic                 ready_w, valid_w, last_w, pop, push;
  logic [6:0]           len_c;
  logic [I_WIDTH-1:0]   mask;
  logic [BUF_WIDTH-1:0] chunk;
  logic [7:0]           shamt;

  // Handshake outputs come straight from registered state, never from inputs.
  assign ready_w = (state_q == S_RUN) && (cnt_q <= PUSH_MAX);
  assign valid_w = (cnt_q >= WORD_CNT) || ((state_q == S_FLUSH) && (cnt_q != 8'd0));
  assign last_w  = (state_q == S_FLUSH) && (cnt_q <= WORD_CNT) && (cnt_q != 8'd0);

  assign pk.push_ready = ready_w;
  assign pk.pop_valid  = valid_w;
  assign pk.pop_last   = last_w;
  assign pk.pop_data   = hold_q[BUF_WIDTH-1 -: O_WIDTH];
  assign pk.done       = (state_q == S_DONE);
  assign pk.word_count = wcount_q;

  assign pop   = valid_w && pk.pop_ready;
  assign push  = pk.push_valid && ready_w;
  assign len_c = (pk.push_len > LEN_MAX) ? LEN_MAX : pk.push_len;
  assign mask  = ~({I_WIDTH{1'b1}} << len_c);
  assign chunk = {{(BUF_WIDTH-I_WIDTH){1'b0}}, pk.push_code & mask};

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    wcount_d = wcount_q;
    shamt    = 8'd0;

    // Pop first so a same-cycle push lands directly behind the surviving bits.
    if (pop) begin
      hold_d   = hold_q << O_WIDTH;
      cnt_d    = (cnt_q >= WORD_CNT) ? (cnt_q - WORD_CNT) : 8'd0;
      wcount_d = wcount_q + 16'd1;
    end

    if (push) begin
      shamt  = BUF_CNT - cnt_d - {1'b0, len_c};
      hold_d = hold_d | (chunk << shamt);
      cnt_d  = cnt_d + {1'b0, len_c};
    end

    case (state_q)
      S_RUN: begin
        if (pk.flush) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if ((cnt_q == 8'd0) || (pop && last_w)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_RUN;
        hold_d  = '0;
        cnt_d   = 8'd0;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      hold_q   <= '0;
      cnt_q    <= 8'd0;
      wcount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      wcount_q <= wcount_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: reset, split, backpressure, push/pop overlap, flushes, clamp/mask.
module tb_bit_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  bit_packer_if #(.I_WIDTH(68), .O_WIDTH(32)) pk ();

  bit_packer dut (
    .clk (clk),
    .rst (rst),
    .pk  (pk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [67:0] c1, c2, c3, ones;
    c1   = 68'hABCDEF0123456789A;
    c2   = 68'hF0F0F0F0F0F0F0F0F;
    c3   = 68'h123456789ABCDEF01;
    ones = 68'hFFFFFFFFFFFFFFFFF;

    pk.push_valid = 1'b0;
    pk.push_code  = '0;
    pk.push_len   = 7'd0;
    pk.flush      = 1'b0;
    pk.pop_ready  = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_valid", 68'(pk.pop_valid), 68'd0);
    chk("rst_ready", 68'(pk.push_ready), 68'd1);
    chk("rst_wc",    68'(pk.word_count), 68'd0);
    chk("rst_data",  68'(pk.pop_data), 68'd0);
    chk("rst_last",  68'(pk.pop_last), 68'd0);
    chk("rst_done",  68'(pk.done), 68'd0);
    rst = 1'b0;

    // two words, one pop, then reset mid-stream
    pk.push_valid = 1'b1; pk.push_code = 68'hDEADBEEF; pk.push_len = 7'd32;
    tick();
    pk.push_code = 68'h12345678;
    chk("a_data0",  68'(pk.pop_data), 68'hDEADBEEF);
    chk("a_valid0", 68'(pk.pop_valid), 68'd1);
    tick();
    pk.push_valid = 1'b0; pk.pop_ready = 1'b1;
    chk("a_stall_data", 68'(pk.pop_data), 68'hDEADBEEF);
    tick();
    pk.pop_ready = 1'b0;
    chk("a_data1", 68'(pk.pop_data), 68'h12345678);
    chk("a_wc1",   68'(pk.word_count), 68'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 68'(pk.pop_valid), 68'd0);
    chk("mid_rst_ready", 68'(pk.push_ready), 68'd1);
    chk("mid_rst_wc",    68'(pk.word_count), 68'd0);
    chk("mid_rst_data",  68'(pk.pop_data), 68'd0);
    #2 rst = 1'b0;
    pk.push_valid = 1'b1; pk.push_code = 68'hDEADBEEF; pk.push_len = 7'd32;
    tick();
    pk.push_valid = 1'b0; pk.pop_ready = 1'b1;
    chk("post_rst_data", 68'(pk.pop_data), 68'hDEADBEEF);
    chk("post_rst_wc",   68'(pk.word_count), 68'd0);
    tick();
    chk("post_rst_pop_wc", 68'(pk.word_count), 68'd1);
    chk("post_rst_empty",  68'(pk.pop_valid), 68'd0);

    // single 34-bit chunk split across a popped word and a flushed tail
    pk.push_valid = 1'b1; pk.push_code = 68'h300000001; pk.push_len = 7'd34;
    tick();
    pk.push_valid = 1'b0;
    chk("b_data0", 68'(pk.pop_data), 68'hC0000000);
    tick();
    chk("b_tail_data",  68'(pk.pop_data), 68'h40000000);
    chk("b_tail_valid", 68'(pk.pop_valid), 68'd0);
    chk("b_wc",         68'(pk.word_count), 68'd2);
    pk.flush = 1'b1; pk.pop_ready = 1'b0;
    tick();
    pk.flush = 1'b0;
    chk("b_fl_valid", 68'(pk.pop_valid), 68'd1);
    chk("b_fl_last",  68'(pk.pop_last), 68'd1);
    chk("b_fl_data",  68'(pk.pop_data), 68'h40000000);
    chk("b_fl_ready", 68'(pk.push_ready), 68'd0);
    chk("b_fl_done",  68'(pk.done), 68'd0);
    pk.pop_ready = 1'b1;
    tick();
    pk.pop_ready = 1'b0;
    chk("b_done",   68'(pk.done), 68'd1);
    chk("b_dvalid", 68'(pk.pop_valid), 68'd0);
    chk("b_dwc",    68'(pk.word_count), 68'd3);
    tick();
    chk("b_done_off", 68'(pk.done), 68'd0);
    chk("b_ready_on", 68'(pk.push_ready), 68'd1);

    // backpressure: fill to 136 bits with a stalled consumer
    pk.push_valid = 1'b1; pk.push_code = c1; pk.push_len = 7'd68;
    tick();
    chk("c_ready68", 68'(pk.push_ready), 68'd1);
    pk.push_code = c2;
    tick();
    pk.push_code = c3;
    chk("c_full_ready", 68'(pk.push_ready), 68'd0);
    chk("c_full_data",  68'(pk.pop_data), 68'hABCDEF01);
    tick();
    chk("c_held_data",  68'(pk.pop_data), 68'hABCDEF01);
    chk("c_held_ready", 68'(pk.push_ready), 68'd0);
    pk.pop_ready = 1'b1;
    tick();
    chk("c_pop1_data",  68'(pk.pop_data), 68'h23456789);
    chk("c_pop1_ready", 68'(pk.push_ready), 68'd0);
    tick();
    chk("c_pop2_data",  68'(pk.pop_data), 68'hAF0F0F0F);
    chk("c_pop2_ready", 68'(pk.push_ready), 68'd0);
    tick();
    chk("c_pop3_data",  68'(pk.pop_data), 68'h0F0F0F0F);
    chk("c_pop3_ready", 68'(pk.push_ready), 68'd1);

    // simultaneous pop and 68-bit push at 40 bits held
    tick();
    pk.push_valid = 1'b0;
    chk("d_data",  68'(pk.pop_data), 68'h0F123456);
    chk("d_ready", 68'(pk.push_ready), 68'd0);
    tick();
    chk("d_next_data",  68'(pk.pop_data), 68'h789ABCDE);
    chk("d_next_ready", 68'(pk.push_ready), 68'd1);
    tick();
    chk("d_tail_valid", 68'(pk.pop_valid), 68'd0);
    pk.flush = 1'b1;
    tick();
    pk.flush = 1'b0;
    chk("d_fl_data", 68'(pk.pop_data), 68'hF0100000);
    chk("d_fl_last", 68'(pk.pop_last), 68'd1);
    tick();
    chk("d_done", 68'(pk.done), 68'd1);
    chk("d_wc",   68'(pk.word_count), 68'd10);
    tick();

    // empty flush
    pk.flush = 1'b1;
    tick();
    pk.flush = 1'b0;
    chk("e_valid", 68'(pk.pop_valid), 68'd0);
    chk("e_done0", 68'(pk.done), 68'd0);
    tick();
    chk("e_done1",  68'(pk.done), 68'd1);
    chk("e_valid1", 68'(pk.pop_valid), 68'd0);
    tick();
    chk("e_done2", 68'(pk.done), 68'd0);
    chk("e_ready", 68'(pk.push_ready), 68'd1);
    chk("e_wc",    68'(pk.word_count), 68'd10);

    // flush with a concurrent push at 20 bits held; upper code bits must be ignored
    pk.push_valid = 1'b1; pk.push_code = 68'hABCDE; pk.push_len = 7'd20;
    tick();
    chk("f_valid20", 68'(pk.pop_valid), 68'd0);
    pk.push_code = ones; pk.push_len = 7'd12; pk.flush = 1'b1;
    tick();
    pk.flush = 1'b0;
    chk("f_ready_blocked", 68'(pk.push_ready), 68'd0);
    chk("f_valid", 68'(pk.pop_valid), 68'd1);
    chk("f_last",  68'(pk.pop_last), 68'd1);
    chk("f_data",  68'(pk.pop_data), 68'hABCDEFFF);
    tick();
    chk("f_done",        68'(pk.done), 68'd1);
    chk("f_done_ready",  68'(pk.push_ready), 68'd0);
    chk("f_wc",          68'(pk.word_count), 68'd11);
    chk("f_done_valid",  68'(pk.pop_valid), 68'd0);
    tick();
    pk.push_valid = 1'b0;
    chk("f_ready_back", 68'(pk.push_ready), 68'd1);
    chk("f_done_off",   68'(pk.done), 68'd0);

    // length clamp (100 -> 68) and masking of code bits above len
    pk.pop_ready = 1'b0;
    pk.push_valid = 1'b1; pk.push_code = c3; pk.push_len = 7'd100;
    tick();
    chk("g_clamp_data", 68'(pk.pop_data), 68'h12345678);
    chk("g_ready68",    68'(pk.push_ready), 68'd1);
    pk.push_code = ones; pk.push_len = 7'd4;
    tick();
    pk.push_valid = 1'b0;
    chk("g_mask_data", 68'(pk.pop_data), 68'h12345678);
    chk("g_ready72",   68'(pk.push_ready), 68'd0);
    pk.pop_ready = 1'b1;
    tick();
    chk("g_pop1", 68'(pk.pop_data), 68'h9ABCDEF0);
    tick();
    chk("g_tail",       68'(pk.pop_data), 68'h1F000000);
    chk("g_tail_valid", 68'(pk.pop_valid), 68'd0);
    chk("g_wc",         68'(pk.word_count), 68'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
